// File: rtl/stopwatch_btn_ctrl_pkg.sv
// Shared state encoding and divider/width helpers for the stopwatch button controller.
package stopwatch_btn_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSE  = 2'd2,
    ST_ADJUST = 2'd3
  } state_t;

  function automatic int unsigned f_clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Bits needed for a counter spanning 0..v-1, never narrower than 1.
  function automatic int unsigned f_width(input int unsigned v);
    return (v < 2) ? 1 : f_clog2(v);
  endfunction

  function automatic int unsigned f_sample_div(input int unsigned clk_hz, input int unsigned sample_hz);
    return clk_hz / sample_hz;
  endfunction

  function automatic int unsigned f_blink_div(input int unsigned sample_hz, input int unsigned blink_hz);
    return sample_hz / (2 * blink_hz);
  endfunction

endpackage

// File: rtl/stopwatch_btn_ctrl_tick_divider.sv
// Enabled modulo-DIV counter emitting a registered one-cycle tick on each wrap; clr restarts it.
module tick_divider
  import stopwatch_btn_ctrl_pkg::*;
#(
  parameter int unsigned DIV = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int unsigned  W    = f_width(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] r_cnt;
  logic         r_tick;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (i_clr) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (i_en) begin
        if (r_cnt == LAST) begin
          r_cnt  <= '0;
          r_tick <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/stopwatch_btn_ctrl.sv
// Stopwatch button controller: debouncer sample strobe, fixed-priority press arbitration and
// IDLE/RUN/PAUSE/ADJUST sequencing. Define BTN_LOCKOUT_EN to add the post-command lockout.
module stopwatch_btn_ctrl
  import stopwatch_btn_ctrl_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 100_000_000,
  parameter int unsigned SAMPLE_HZ     = 1_000,
  parameter int unsigned BLINK_HZ      = 2,
  parameter int unsigned LOCKOUT_TICKS = 50
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  output logic       o_sample_en,
  input  logic       i_pause_p,
  input  logic       i_reset_p,
  input  logic       i_adj_p,
  input  logic       i_sel_p,
  output logic       o_run,
  output logic       o_clear,
  output logic       o_adj_mode,
  output logic       o_adj_sel,
  output logic       o_adj_blink,
  output logic [1:0] o_state
);

  localparam int unsigned SAMPLE_DIV = f_sample_div(CLK_HZ, SAMPLE_HZ);
  localparam int unsigned BLINK_DIV  = f_blink_div(SAMPLE_HZ, BLINK_HZ);

  if (SAMPLE_DIV < 2 || BLINK_DIV < 1 || LOCKOUT_TICKS > 32'h00FF_FFFF) begin : g_param_check
    $error("stopwatch_btn_ctrl: unsupported clock/sample/blink/lockout parameters");
  end

  state_t r_state;
  logic   r_run, r_clear, r_adj_mode, r_adj_sel, r_adj_blink;
  logic   w_sample_en, w_blink_tick, w_locked;
  logic   w_in_adj, w_do_reset, w_do_adj, w_do_pause, w_do_sel, w_adj_entry;

  tick_divider #(.DIV(SAMPLE_DIV)) u_sample_div (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (1'b1),
    .i_clr   (1'b0),
    .o_tick  (w_sample_en)
  );

  // Blink phase only advances while adjusting and restarts on every entry.
  tick_divider #(.DIV(BLINK_DIV)) u_blink_div (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (w_sample_en && w_in_adj),
    .i_clr   (w_adj_entry),
    .o_tick  (w_blink_tick)
  );

  // Priority is decided before lockout, so a locked-out winner still suppresses the losers.
  always_comb begin
    w_in_adj    = (r_state == ST_ADJUST);
    w_do_reset  = i_reset_p;
    w_do_adj    = !i_reset_p && i_adj_p && !w_locked;
    w_do_pause  = !i_reset_p && !i_adj_p && i_pause_p && !w_locked;
    w_do_sel    = !i_reset_p && !i_adj_p && !i_pause_p && i_sel_p && !w_locked;
    w_adj_entry = w_do_adj && !w_in_adj;
  end

`ifdef BTN_LOCKOUT_EN
  localparam int unsigned LOCK_W = f_width(LOCKOUT_TICKS + 1);

  logic [LOCK_W-1:0] r_lock_cnt;
  logic              w_accept;

  assign w_accept = w_do_reset || w_do_adj || (w_do_pause && !w_in_adj) || (w_do_sel && w_in_adj);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lock_cnt <= '0;
    end else if (w_accept) begin
      r_lock_cnt <= LOCK_W'(LOCKOUT_TICKS);
    end else if (w_sample_en && (r_lock_cnt != '0)) begin
      r_lock_cnt <= r_lock_cnt - 1'b1;
    end
  end

  assign w_locked = (r_lock_cnt != '0);
`else
  assign w_locked = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_run       <= 1'b0;
      r_clear     <= 1'b0;
      r_adj_mode  <= 1'b0;
      r_adj_sel   <= 1'b0;
      r_adj_blink <= 1'b1;
    end else begin
      r_clear <= 1'b0;
      if (w_do_reset) begin
        r_state     <= ST_IDLE;
        r_run       <= 1'b0;
        r_clear     <= 1'b1;
        r_adj_mode  <= 1'b0;
        r_adj_sel   <= 1'b0;
        r_adj_blink <= 1'b1;
      end else if (w_do_adj) begin
        r_adj_blink <= 1'b1;
        if (w_in_adj) begin
          r_state    <= ST_PAUSE;
          r_adj_mode <= 1'b0;
        end else begin
          r_state    <= ST_ADJUST;
          r_run      <= 1'b0;
          r_adj_mode <= 1'b1;
        end
      end else if (w_do_pause && !w_in_adj) begin
        if (r_state == ST_RUN) begin
          r_state <= ST_PAUSE;
          r_run   <= 1'b0;
        end else begin
          r_state <= ST_RUN;
          r_run   <= 1'b1;
        end
      end else if (w_in_adj) begin
        if (w_do_sel)     r_adj_sel   <= ~r_adj_sel;
        if (w_blink_tick) r_adj_blink <= ~r_adj_blink;
      end
    end
  end

  assign o_sample_en = w_sample_en;
  assign o_run       = r_run;
  assign o_clear     = r_clear;
  assign o_adj_mode  = r_adj_mode;
  assign o_adj_sel   = r_adj_sel;
  assign o_adj_blink = r_adj_blink;
  assign o_state     = r_state;

endmodule

// File: tb/tb_stopwatch_btn_ctrl.sv
// Self-checking bench for stopwatch_btn_ctrl: vector table, corner sequences, randomized run vs model.
module tb_stopwatch_btn_ctrl;

  localparam int unsigned CLK_HZ        = 1000;
  localparam int unsigned SAMPLE_HZ     = 100;
  localparam int unsigned BLINK_HZ      = 5;
  localparam int unsigned LOCKOUT_TICKS = 3;
  localparam int          SDIV          = CLK_HZ / SAMPLE_HZ;
  localparam int          BDIV          = SAMPLE_HZ / (2 * BLINK_HZ);
`ifdef BTN_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pause_p = 1'b0, reset_p = 1'b0, adj_p = 1'b0, sel_p = 1'b0;
  logic       sample_en, run, clear, adj_mode, adj_sel, adj_blink;
  logic [1:0] state;

  int n_checks = 0;
  int n_errors = 0;

  int m_cyc, m_state, m_lock, m_bsamples;
  bit m_se, m_btick, m_clear, m_adj_sel, m_blink;

  always #5 clk = ~clk;

  stopwatch_btn_ctrl #(
    .CLK_HZ(CLK_HZ), .SAMPLE_HZ(SAMPLE_HZ), .BLINK_HZ(BLINK_HZ), .LOCKOUT_TICKS(LOCKOUT_TICKS)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .o_sample_en(sample_en),
    .i_pause_p(pause_p), .i_reset_p(reset_p), .i_adj_p(adj_p), .i_sel_p(sel_p),
    .o_run(run), .o_clear(clear), .o_adj_mode(adj_mode), .o_adj_sel(adj_sel),
    .o_adj_blink(adj_blink), .o_state(state)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      if (n_errors <= 40) $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] dut_vec();
    return {sample_en, run, clear, adj_mode, adj_sel, adj_blink, state};
  endfunction

  // Outputs are derived from the abstract state: run <=> RUN, adj_mode <=> ADJUST.
  function automatic logic [7:0] model_vec();
    return {m_se, (m_state == 1), m_clear, (m_state == 3), m_adj_sel, m_blink, 2'(m_state)};
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_state = 0; m_lock = 0; m_bsamples = 0;
    m_se = 0; m_btick = 0; m_clear = 0; m_adj_sel = 0; m_blink = 1;
  endtask

  // One clock of the behavioural model: win = 1 reset, 2 adjust, 3 pause, 4 select, 0 none.
  task automatic model_step(input bit p, input bit r, input bit a, input bit s);
    int win, st0;
    bit se_now, tick_now, acc, entry;
    se_now = m_se; tick_now = m_btick; st0 = m_state;
    m_cyc++;
    win = r ? 1 : a ? 2 : p ? 3 : s ? 4 : 0;
    if (win > 1 && LOCK_EN && m_lock > 0) win = 0;
    acc   = (win == 1) || (win == 2) || (win == 3 && st0 != 3) || (win == 4 && st0 == 3);
    entry = (win == 2) && (st0 != 3);
    m_btick = 0;
    if (entry) m_bsamples = 0;
    else if (st0 == 3 && se_now) begin
      m_bsamples++;
      if (m_bsamples % BDIV == 0) m_btick = 1;
    end
    m_clear = 0;
    case (win)
      1: begin m_state = 0; m_adj_sel = 0; m_clear = 1; m_blink = 1; end
      2: begin m_state = (st0 == 3) ? 2 : 3; m_blink = 1; end
      3: if (st0 == 1) m_state = 2; else if (st0 != 3) m_state = 1;
      4: if (st0 == 3) m_adj_sel = !m_adj_sel;
      default: ;
    endcase
    if (win != 1 && win != 2 && st0 == 3 && tick_now) m_blink = !m_blink;
    if (acc) m_lock = LOCKOUT_TICKS;
    else if (se_now && m_lock > 0) m_lock--;
    m_se = (m_cyc % SDIV == 0);
  endtask

  task automatic do_cycle(input bit p, input bit r, input bit a, input bit s);
    pause_p = p; reset_p = r; adj_p = a; sel_p = s;
    @(posedge clk);
    model_step(p, r, a, s);
    @(negedge clk);
    check("model", dut_vec(), model_vec());
    pause_p = 0; reset_p = 0; adj_p = 0; sel_p = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(0, 0, 0, 0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    pause_p = 0; reset_p = 0; adj_p = 0; sel_p = 0;
    model_reset();
    check("reset_vec", dut_vec(), 8'h04);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit p, r, a, s;
    logic [1:0] st;
    bit run, clr, am, as;
  } vec_t;

  vec_t tbl[14];
  int   exp_lock[5];
  int   t1, t2, k;

  initial begin
    tbl[0]  = '{0, 0, 0, 1, 2'd0, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 0, 0, 2'd1, 1, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 1, 2'd1, 1, 0, 0, 0};
    tbl[3]  = '{1, 0, 0, 0, 2'd2, 0, 0, 0, 0};
    tbl[4]  = '{1, 0, 0, 0, 2'd1, 1, 0, 0, 0};
    tbl[5]  = '{1, 0, 1, 0, 2'd3, 0, 0, 1, 0};
    tbl[6]  = '{1, 0, 0, 1, 2'd3, 0, 0, 1, 0};
    tbl[7]  = '{0, 0, 0, 1, 2'd3, 0, 0, 1, 1};
    tbl[8]  = '{0, 0, 1, 1, 2'd2, 0, 0, 0, 1};
    tbl[9]  = '{0, 0, 1, 0, 2'd3, 0, 0, 1, 1};
    tbl[10] = '{0, 1, 1, 0, 2'd0, 0, 1, 0, 0};
    tbl[11] = '{0, 0, 0, 0, 2'd0, 0, 0, 0, 0};
    tbl[12] = '{0, 0, 1, 0, 2'd3, 0, 0, 1, 0};
    tbl[13] = '{1, 1, 0, 1, 2'd0, 0, 1, 0, 0};

    repeat (2) @(negedge clk);
    apply_reset();

    for (int i = 1; i <= 40; i++) begin
      do_cycle(0, 0, 0, 0);
      check("sample_en", sample_en, (i % SDIV == 0) ? 1 : 0);
    end
    check("idle_state", {state, adj_blink}, 3'b001);

    for (int i = 0; i < 14; i++) begin
      do_cycle(tbl[i].p, tbl[i].r, tbl[i].a, tbl[i].s);
      check($sformatf("tbl%0d", i), {state, run, clear, adj_mode, adj_sel},
            {tbl[i].st, tbl[i].run, tbl[i].clr, tbl[i].am, tbl[i].as});
      idle(40);
    end

    // Blink cadence in ADJUST, then a reset_p landing on a blink wrap.
    do_cycle(0, 0, 1, 0);
    check("adj_entry", {state, adj_blink}, 3'b111);
    t1 = -1; t2 = -1; k = 0;
    while (k < 600) begin
      k++;
      if (t1 > 0 && k == t1 + 2 * 100) begin
        do_cycle(0, 1, 0, 0);
        break;
      end
      do_cycle(0, 0, 0, 0);
      if (t1 < 0 && adj_blink == 1'b0) t1 = k;
      if (t1 > 0 && t2 < 0 && adj_blink == 1'b1) t2 = k;
    end
    check("blink_first", (t1 >= 92 && t1 <= 101) ? 1 : 0, 1);
    check("blink_period", t2 - t1, 100);
    check("reset_over_blink", {state, clear, adj_blink, adj_mode}, 5'b00110);
    idle(40);

`ifdef BTN_LOCKOUT_EN
    exp_lock = '{1, 1, 2, 2, 0};
`else
    exp_lock = '{1, 2, 1, 2, 0};
`endif
    do_cycle(1, 0, 0, 0);
    check("lock_first", state, exp_lock[0]);
    idle(14);
    do_cycle(1, 0, 0, 0);
    check("lock_15", state, exp_lock[1]);
    idle(19);
    do_cycle(1, 0, 0, 0);
    check("lock_35", state, exp_lock[2]);
    do_cycle(1, 0, 0, 0);
    check("lock_again", state, exp_lock[3]);
    do_cycle(0, 1, 0, 0);
    check("lock_reset", {state, clear}, {2'(exp_lock[4]), 1'b1});
    idle(40);

    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        pause_p = 1'b1;
        #2;
        apply_reset();
        check("async_no_clear", clear, 0);
      end
      do_cycle(($urandom % 8) == 0, ($urandom % 48) == 0, ($urandom % 10) == 0, ($urandom % 6) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
